// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: drives one column at a time, synchronises and
// debounces the row returns, and commits single key presses as hex codes with press/release events.
module keypad_scanner #(
    parameter int unsigned SETTLE_CYCLES  = 50_000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_held,
    output logic       multi_key
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES);
    localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] STABLE_MAX  = DW'(DEBOUNCE_SCANS);

    typedef enum logic {StDrive, StEval} state_t;
    typedef enum logic [1:0] {ResNone, ResSingle, ResMulti} res_t;

    state_t          state_q, state_d;
    logic [1:0]      col_q, col_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [3:0][3:0] scan_q, scan_d;  // [column][row], 1 = pressed
    res_t            prev_res_q, prev_res_d;
    logic [3:0]      prev_code_q, prev_code_d;
    logic [DW-1:0]   stable_q, stable_d;
    logic [3:0]      code_q, code_d;
    logic            held_q, held_d;
    logic            multi_q, multi_d;
    logic            valid_q, valid_d;
    logic            release_q, release_d;
    logic [3:0]      row_meta_q, row_sync_q;

    res_t            res_class;
    logic [3:0]      res_code;
    logic [4:0]      n_keys;
    logic            res_same;
    logic            commit;

    function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        unique case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
        end
    end

    // Classify the completed scan map; code is forced to 0 unless exactly one key is down.
    always_comb begin
        n_keys   = '0;
        res_code = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (scan_q[c][r]) begin
                    n_keys   = n_keys + 5'd1;
                    res_code = key_lut(2'(r), 2'(c));
                end
            end
        end
        if (n_keys == 5'd0) begin
            res_class = ResNone;
        end else if (n_keys == 5'd1) begin
            res_class = ResSingle;
        end else begin
            res_class = ResMulti;
        end
        if (res_class != ResSingle) res_code = '0;
        res_same = (res_class == prev_res_q) && (res_code == prev_code_q);
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        settle_d    = settle_q;
        scan_d      = scan_q;
        prev_res_d  = prev_res_q;
        prev_code_d = prev_code_q;
        stable_d    = stable_q;
        code_d      = code_q;
        held_d      = held_q;
        multi_d     = multi_q;
        valid_d     = 1'b0;
        release_d   = 1'b0;
        commit      = 1'b0;

        unique case (state_q)
            StDrive: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d       = '0;
                    scan_d[col_q]  = ~row_sync_q;
                    if (col_q == 2'd3) begin
                        state_d = StEval;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StEval: begin
                state_d     = StDrive;
                col_d       = 2'd0;
                prev_res_d  = res_class;
                prev_code_d = res_code;
                if (res_same) begin
                    stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 1'b1;
                end else begin
                    stable_d = DW'(1);
                end
                // Commit only on the scan where the count first reaches the threshold.
                commit = (stable_d == STABLE_MAX) && !(res_same && stable_q == STABLE_MAX);
                if (commit) begin
                    unique case (res_class)
                        ResSingle: begin
                            multi_d = 1'b0;
                            if (res_code != code_q || !held_q) begin
                                code_d  = res_code;
                                held_d  = 1'b1;
                                valid_d = 1'b1;
                            end
                        end
                        ResNone: begin
                            multi_d = 1'b0;
                            if (held_q) begin
                                held_d    = 1'b0;
                                release_d = 1'b1;
                            end
                        end
                        default: multi_d = 1'b1;
                    endcase
                end
            end
            default: state_d = StDrive;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StDrive;
            col_q       <= 2'd0;
            settle_q    <= '0;
            scan_q      <= '0;
            prev_res_q  <= ResNone;
            prev_code_q <= '0;
            stable_q    <= '0;
            code_q      <= '0;
            held_q      <= 1'b0;
            multi_q     <= 1'b0;
            valid_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            settle_q    <= settle_d;
            scan_q      <= scan_d;
            prev_res_q  <= prev_res_d;
            prev_code_q <= prev_code_d;
            stable_q    <= stable_d;
            code_q      <= code_d;
            held_q      <= held_d;
            multi_q     <= multi_d;
            valid_q     <= valid_d;
            release_q   <= release_d;
        end
    end

    // Column index stays at 3 through EVAL, so exactly one column is always low.
    assign col_out     = ~(4'b0001 << col_q);
    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_release = release_q;
    assign key_held    = held_q;
    assign multi_key   = multi_q;

endmodule
